// File: rtl/rank_pipe_drain.sv
// Drains (rank, meta) entries from a first-word-fall-through rank block into a PIFO
// insert port through a 2-entry elastic buffer, with flush discard and saturating stats.
module rank_pipe_drain #(
    parameter int RANK_WIDTH = 16,
    parameter int META_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rank_valid,
    input  logic [RANK_WIDTH-1:0] rank_in,
    input  logic [META_WIDTH-1:0] meta_in,
    output logic                  rank_remove,
    input  logic                  pifo_busy,
    output logic                  pifo_insert,
    output logic [RANK_WIDTH-1:0] pifo_rank,
    output logic [META_WIDTH-1:0] pifo_meta,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  fwd_count,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic                  idle
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t                  occ_reg, occ_next;
    logic [RANK_WIDTH-1:0] head_rank_reg, head_rank_next;
    logic [META_WIDTH-1:0] head_meta_reg, head_meta_next;
    logic [RANK_WIDTH-1:0] skid_rank_reg, skid_rank_next;
    logic [META_WIDTH-1:0] skid_meta_reg, skid_meta_next;
    logic                  push, pop;
    logic [1:0]            occ_bits;
    logic [1:0]            cnt_inc [2];

    // Upstream pop never looks at pifo_busy; the skid slot absorbs the one-cycle lag.
    assign rank_remove = !rst && rank_valid && (flush || occ_reg != TWO);
    assign pifo_insert = !rst && !flush && occ_reg != EMPTY && !pifo_busy;
    assign push        = rank_remove && !flush;
    assign pop         = pifo_insert;

    assign pifo_rank = head_rank_reg;
    assign pifo_meta = head_meta_reg;
    assign idle      = (occ_reg == EMPTY) && !rank_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_reg       <= EMPTY;
            head_rank_reg <= '0;
            head_meta_reg <= '0;
            skid_rank_reg <= '0;
            skid_meta_reg <= '0;
        end else begin
            occ_reg       <= occ_next;
            head_rank_reg <= head_rank_next;
            head_meta_reg <= head_meta_next;
            skid_rank_reg <= skid_rank_next;
            skid_meta_reg <= skid_meta_next;
        end
    end

    always_comb begin
        occ_next       = occ_reg;
        head_rank_next = head_rank_reg;
        head_meta_next = head_meta_reg;
        skid_rank_next = skid_rank_reg;
        skid_meta_next = skid_meta_reg;
        if (flush) begin
            occ_next = EMPTY;
        end else begin
            case (occ_reg)
                EMPTY: begin
                    if (push) begin
                        head_rank_next = rank_in;
                        head_meta_next = meta_in;
                        occ_next       = ONE;
                    end
                end
                ONE: begin
                    case ({push, pop})
                        2'b11: begin
                            head_rank_next = rank_in;
                            head_meta_next = meta_in;
                        end
                        2'b10: begin
                            skid_rank_next = rank_in;
                            skid_meta_next = meta_in;
                            occ_next       = TWO;
                        end
                        2'b01: occ_next = EMPTY;
                        default: occ_next = ONE;
                    endcase
                end
                TWO: begin
                    // push is impossible here, so only the skid-to-head move remains
                    if (pop) begin
                        head_rank_next = skid_rank_reg;
                        head_meta_next = skid_meta_reg;
                        occ_next       = ONE;
                    end
                end
                default: occ_next = EMPTY;
            endcase
        end
    end

    // Statistics: index 0 counts inserts, index 1 counts flushed entries (0..3 per cycle).
    assign occ_bits   = occ_reg;
    assign cnt_inc[0] = {1'b0, pifo_insert};
    assign cnt_inc[1] = flush ? (occ_bits + {1'b0, rank_remove}) : 2'd0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_reg;
            logic [CNT_WIDTH:0]   sum;

            assign sum = {1'b0, cnt_reg} + (CNT_WIDTH + 1)'(cnt_inc[gi]);

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (sum[CNT_WIDTH]) begin
                    cnt_reg <= '1;
                end else begin
                    cnt_reg <= sum[CNT_WIDTH-1:0];
                end
            end
        end
    endgenerate

    assign fwd_count  = g_cnt[0].cnt_reg;
    assign drop_count = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_rank_pipe_drain.sv
// Directed bench for rank_pipe_drain: FWFT upstream model feeding the DUT, in-order
// scoreboard on the PIFO side, plus a narrow-counter instance for saturation.
module tb_rank_pipe_drain;

    localparam int RW = 16;
    localparam int MW = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rank_valid = 1'b0;
    logic [RW-1:0] rank_in = '0;
    logic [MW-1:0] meta_in = '0;
    logic          pifo_busy = 1'b0;
    logic          flush = 1'b0;

    logic          rank_remove, pifo_insert, idle;
    logic [RW-1:0] pifo_rank;
    logic [MW-1:0] pifo_meta;
    logic [CW-1:0] fwd_count, drop_count;

    logic          rank_remove4, pifo_insert4, idle4;
    logic [RW-1:0] pifo_rank4;
    logic [MW-1:0] pifo_meta4;
    logic [3:0]    fwd_count4, drop_count4;

    rank_pipe_drain #(.RANK_WIDTH(RW), .META_WIDTH(MW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .rank_valid(rank_valid), .rank_in(rank_in), .meta_in(meta_in),
        .rank_remove(rank_remove), .pifo_busy(pifo_busy), .pifo_insert(pifo_insert),
        .pifo_rank(pifo_rank), .pifo_meta(pifo_meta), .flush(flush),
        .fwd_count(fwd_count), .drop_count(drop_count), .idle(idle)
    );

    // Same stimulus, 4-bit counters: behaves identically except for saturation.
    rank_pipe_drain #(.RANK_WIDTH(RW), .META_WIDTH(MW), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .rank_valid(rank_valid), .rank_in(rank_in), .meta_in(meta_in),
        .rank_remove(rank_remove4), .pifo_busy(pifo_busy), .pifo_insert(pifo_insert4),
        .pifo_rank(pifo_rank4), .pifo_meta(pifo_meta4), .flush(flush),
        .fwd_count(fwd_count4), .drop_count(drop_count4), .idle(idle4)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] up_q[$];
    logic [31:0] exp_q[$];
    logic        last_rem, last_ins, last_idle;
    int          max_occ = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push_entry(input int r);
        logic [15:0] rk;
        logic [15:0] mt;
        rk = 16'(r);
        mt = 16'(r + 16'h100);
        up_q.push_back({rk, mt});
    endtask

    // One clock: drive at negedge, sample 1ns later, let the rising edge happen.
    task automatic cycle(input logic rs, input logic busy, input logic fl);
        logic [31:0] e;
        @(negedge clk);
        rst        = rs;
        pifo_busy  = busy;
        flush      = fl;
        rank_valid = (up_q.size() > 0);
        if (up_q.size() > 0) {rank_in, meta_in} = up_q[0];
        #1;
        last_rem  = rank_remove;
        last_ins  = pifo_insert;
        last_idle = idle;
        if (pifo_insert) begin
            if (exp_q.size() == 0) begin
                check("ins_unexpected", {31'd0, pifo_insert}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("ins_data", {pifo_rank, pifo_meta}, e);
            end
        end
        if (rank_remove) begin
            e = up_q.pop_front();
            if (!fl) exp_q.push_back(e);
        end
        if (fl || rs) exp_q.delete();
        if (exp_q.size() > max_occ) max_occ = exp_q.size();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] rem3;
        logic [8:0] ins3;
        int         n;
        int         ins_cnt;

        // Reset behaviour
        cycle(1'b1, 1'b0, 1'b0);
        check("rst_idle_empty", {31'd0, last_idle}, 32'd1);
        for (int r = 1; r <= 8; r++) push_entry(r);
        cycle(1'b1, 1'b0, 1'b0);
        check("rst_rem", {31'd0, last_rem}, 32'd0);
        check("rst_ins", {31'd0, last_ins}, 32'd0);
        check("rst_idle_valid", {31'd0, last_idle}, 32'd0);
        check("rst_fwd", fwd_count, 32'd0);
        check("rst_drop", drop_count, 32'd0);

        // Stream 1..8 at full rate
        for (int k = 0; k < 9; k++) begin
            cycle(1'b0, 1'b0, 1'b0);
            check("t2_rem", {31'd0, last_rem}, {31'd0, k <= 7});
            check("t2_ins", {31'd0, last_ins}, {31'd0, k >= 1});
        end
        cycle(1'b0, 1'b0, 1'b0);
        check("t2_idle", {31'd0, last_idle}, 32'd1);
        check("t2_fwd", fwd_count, 32'd8);
        check("t2_fwd4", {28'd0, fwd_count4}, 32'd8);

        // Backpressure: busy for 5 cycles, buffer fills to two
        for (int r = 1; r <= 4; r++) push_entry(r);
        rem3 = 9'b011000011;
        ins3 = 9'b111100000;
        for (int k = 0; k < 9; k++) begin
            cycle(1'b0, k < 5, 1'b0);
            check("t3_rem", {31'd0, last_rem}, {31'd0, rem3[k]});
            check("t3_ins", {31'd0, last_ins}, {31'd0, ins3[k]});
        end
        check("t3_fwd", fwd_count, 32'd12);

        // Flush with buffer full and three entries waiting upstream
        push_entry(5);
        push_entry(6);
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b1, 1'b0);
            check("t4_fill_rem", {31'd0, last_rem}, 32'd1);
        end
        push_entry(7);
        push_entry(8);
        push_entry(16'hAA);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 1'b1);
            check("t4_flush_rem", {31'd0, last_rem}, 32'd1);
            check("t4_flush_ins", {31'd0, last_ins}, 32'd0);
        end
        check("t4_drop", drop_count, 32'd5);
        check("t4_fwd", fwd_count, 32'd12);
        cycle(1'b0, 1'b0, 1'b0);
        check("t4_idle", {31'd0, last_idle}, 32'd1);
        push_entry(9);
        cycle(1'b0, 1'b0, 1'b0);
        check("t4_e9_ins0", {31'd0, last_ins}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        check("t4_e9_ins1", {31'd0, last_ins}, 32'd1);
        check("t4_fwd_after", fwd_count, 32'd13);

        // Alternating busy over 20 entries
        for (int r = 16'h20; r < 16'h34; r++) push_entry(r);
        n = 0;
        ins_cnt = 0;
        max_occ = 0;
        while ((up_q.size() > 0 || exp_q.size() > 0) && n < 200) begin
            cycle(1'b0, n[0], 1'b0);
            if (last_ins) ins_cnt++;
            n++;
        end
        check("t5_drained", up_q.size() + exp_q.size(), 32'd0);
        check("t5_ins_cnt", ins_cnt, 32'd20);
        check("t5_max_occ_le2", {31'd0, max_occ <= 2}, 32'd1);
        check("t5_fwd", fwd_count, 32'd33);
        check("t6_fwd4_sat", {28'd0, fwd_count4}, 32'd15);
        check("t6_drop4", {28'd0, drop_count4}, 32'd5);

        // Reset mid-operation: two buffered entries lost, third still upstream
        push_entry(16'h50);
        push_entry(16'h51);
        push_entry(16'h52);
        for (int k = 0; k < 2; k++) cycle(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b1, 1'b0);
            check("t7_rst_rem", {31'd0, last_rem}, 32'd0);
            check("t7_rst_ins", {31'd0, last_ins}, 32'd0);
        end
        check("t7_fwd_clr", fwd_count, 32'd0);
        check("t7_drop_clr", drop_count, 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        check("t7_rem", {31'd0, last_rem}, 32'd1);
        check("t7_ins0", {31'd0, last_ins}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        check("t7_ins1", {31'd0, last_ins}, 32'd1);
        check("t7_fwd", fwd_count, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
